sram_port_arbiter: RTL and testbench

Arbitrates the core's instruction-fetch port (IF) and data port (EX/MEM) onto one shared SRAM-like bus with address/data handshakes, so the core can sit behind a single memory interface. Sits between `mycpu_core` and the SoC memory bridge. Issues one transaction at a time, gives data priority with a starvation guard for fetch, and drives a pipeline stall request to CTRL while any access is unresolved.

---
 rtl/sram_port_arbiter_pkg.sv | 35 +++
 rtl/sram_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the IF/data-to-single-SRAM-bus arbiter: FSM states, grant encoding, latched bus payload.
`timescale 1ns/1ps
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } grant_e;

    localparam int unsigned STARVE_MAX_DEFAULT = 4;

    typedef struct packed {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_hdr_t;

    // Fetches are always plain reads, so only the address is carried.
    function automatic bus_hdr_t inst_hdr(input logic [31:0] addr);
        bus_hdr_t h;
        h.wr    = 1'b0;
        h.wstrb = 4'h0;
        h.addr  = addr;
        h.wdata = 32'h0;
        return h;
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Merges the IF and data ports onto one SRAM-like bus, one transaction at a time; data wins unless fetch is starved.
// Latency: request in IDLE -> bus_req next cycle; 3 cycles minimum per transaction with a zero-wait slave.
// Backpressure: requesters hold req until *_addr_ok; stallreq stays high while any access is unresolved.
`timescale 1ns/1ps
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,

    output logic        stallreq
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e       state_q, state_d;
    grant_e           grant_q, grant_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    bus_hdr_t         hdr_q, hdr_d;

    logic starve_hit;
    logic pick_data;

    assign starve_hit = (starve_cnt_q == CNT_MAX);
    assign pick_data  = data_req && !(inst_req && starve_hit);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        starve_cnt_d = starve_cnt_q;
        hdr_d        = hdr_q;
        case (state_q)
            ARB_IDLE: begin
                if (inst_req || data_req) begin
                    state_d = ARB_ADDR;
                    if (pick_data) begin
                        grant_d     = GRANT_DATA;
                        hdr_d.wr    = data_wr;
                        hdr_d.wstrb = data_wstrb;
                        hdr_d.addr  = data_addr;
                        hdr_d.wdata = data_wdata;
                        // Only a data win over a waiting fetch counts towards starvation.
                        if (!inst_req) begin
                            starve_cnt_d = '0;
                        end else if (!starve_hit) begin
                            starve_cnt_d = starve_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        grant_d      = GRANT_INST;
                        hdr_d        = inst_hdr(inst_addr);
                        starve_cnt_d = '0;
                    end
                end
            end
            ARB_ADDR: begin
                if (bus_addr_ok) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (bus_data_ok) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ARB_IDLE;
            grant_q      <= GRANT_INST;
            starve_cnt_q <= '0;
            hdr_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            starve_cnt_q <= starve_cnt_d;
            hdr_q        <= hdr_d;
        end
    end

    logic in_addr;
    logic in_data;

    assign in_addr = (state_q == ARB_ADDR);
    assign in_data = (state_q == ARB_DATA);

    assign bus_req   = in_addr;
    assign bus_wr    = hdr_q.wr;
    assign bus_wstrb = hdr_q.wstrb;
    assign bus_addr  = hdr_q.addr;
    assign bus_wdata = hdr_q.wdata;

    assign inst_addr_ok = in_addr && bus_addr_ok && (grant_q == GRANT_INST);
    assign data_addr_ok = in_addr && bus_addr_ok && (grant_q == GRANT_DATA);
    assign inst_data_ok = in_data && bus_data_ok && (grant_q == GRANT_INST);
    assign data_data_ok = in_data && bus_data_ok && (grant_q == GRANT_DATA);

    assign inst_rdata = (in_data && (grant_q == GRANT_INST)) ? bus_rdata : 32'h0;
    assign data_rdata = (in_data && (grant_q == GRANT_DATA)) ? bus_rdata : 32'h0;

    assign stallreq = ((state_q == ARB_IDLE) && (inst_req || data_req))
                    || in_addr
                    || (in_data && !bus_data_ok);

    a_late_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        (state_q == ARB_IDLE) |-> !bus_data_ok)
        else $warning("bus_data_ok with no outstanding transaction, ignored");

    a_inst_req_held: assert property (@(posedge clk) disable iff (!resetn)
        (inst_req && !inst_addr_ok) |=> inst_req)
        else $error("inst_req dropped before inst_addr_ok");

    a_data_req_held: assert property (@(posedge clk) disable iff (!resetn)
        (data_req && !data_addr_ok) |=> data_req)
        else $error("data_req dropped before data_addr_ok");

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: expected bus payloads and responses queued at stimulus time, checked as the DUT produces them.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

    localparam int S_IDLE = 0;
    localparam int S_ADDR = 1;
    localparam int S_DATA = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        stallreq;

    sram_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          src;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
    } rsp_exp_t;

    bus_exp_t    exp_bus_q[$];
    logic [31:0] exp_inst_q[$];
    rsp_exp_t    exp_data_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave memory contents: two fixed words from the test plan, everything else address-derived.
    function automatic logic [31:0] rsp_fn(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C1D_0000;
        if (a == 32'h8000_2004) return 32'h1234_5678;
        return a ^ 32'hA5A5_0F0F;
    endfunction

    // Reference arbiter phase, independent of the DUT.
    int m_st = S_IDLE;
    always @(posedge clk) begin
        if (!resetn) m_st = S_IDLE;
        else case (m_st)
            S_IDLE: if (inst_req || data_req) m_st = S_ADDR;
            S_ADDR: if (bus_addr_ok) m_st = S_DATA;
            S_DATA: if (bus_data_ok) m_st = S_IDLE;
            default: m_st = S_IDLE;
        endcase
    end

    int          addr_dly = 0;
    int          data_dly = 0;
    int          wcnt = 0;
    bit          slave_en = 1'b1;
    bit          addr_fire = 1'b0;
    bit          data_fire = 1'b0;
    bit          cur_src = 1'b0;
    logic [31:0] cur_rd = '0;
    bus_exp_t    s_e;

    always @(negedge resetn) begin
        m_st = S_IDLE;
        wcnt = 0;
        exp_bus_q.delete();
        exp_inst_q.delete();
        exp_data_q.delete();
    end

    always @(posedge clk) begin
        #1;
        addr_fire = 1'b0;
        data_fire = 1'b0;
        if (slave_en) begin
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            bus_rdata   = $urandom;
        end
        if (slave_en && resetn) begin
            if (m_st == S_ADDR) begin
                chk("bus_req_in_addr", bus_req, 1);
                if (exp_bus_q.size() == 0) begin
                    chk("bus_unexpected_txn", 1, 0);
                end else begin
                    s_e = exp_bus_q[0];
                    chk("bus_wr", bus_wr, s_e.wr);
                    chk("bus_wstrb", bus_wstrb, s_e.strb);
                    chk("bus_addr", bus_addr, s_e.addr);
                    chk("bus_wdata", bus_wdata, s_e.wdata);
                end
                if (wcnt >= addr_dly) begin
                    bus_addr_ok = 1'b1;
                    addr_fire   = 1'b1;
                    wcnt        = 0;
                    if (exp_bus_q.size() != 0) begin
                        cur_src = s_e.src;
                        cur_rd  = rsp_fn(s_e.addr);
                        void'(exp_bus_q.pop_front());
                    end
                end else begin
                    wcnt++;
                end
            end else if (m_st == S_DATA) begin
                chk("bus_req_in_data", bus_req, 0);
                if (wcnt >= data_dly) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = cur_rd;
                    data_fire   = 1'b1;
                    wcnt        = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                chk("bus_req_in_idle", bus_req, 0);
                wcnt = 0;
            end
        end
    end

    logic        stall_exp;
    logic [31:0] e_rd;
    rsp_exp_t    e_rsp;
    always @(negedge clk) begin
        chk("inst_addr_ok", inst_addr_ok, addr_fire && !cur_src);
        chk("data_addr_ok", data_addr_ok, addr_fire && cur_src);
        chk("inst_data_ok", inst_data_ok, data_fire && !cur_src);
        chk("data_data_ok", data_data_ok, data_fire && cur_src);
        stall_exp = (m_st == S_IDLE && (inst_req || data_req)) || (m_st == S_ADDR)
                  || (m_st == S_DATA && !bus_data_ok);
        chk("stallreq", stallreq, stall_exp);
        if (inst_data_ok) begin
            if (exp_inst_q.size() == 0) chk("inst_rsp_unexpected", 1, 0);
            else begin
                e_rd = exp_inst_q.pop_front();
                chk("inst_rdata", inst_rdata, e_rd);
            end
        end
        if (data_data_ok) begin
            if (exp_data_q.size() == 0) chk("data_rsp_unexpected", 1, 0);
            else begin
                e_rsp = exp_data_q.pop_front();
                if (!e_rsp.wr) chk("data_rdata", data_rdata, e_rsp.rdata);
            end
        end
    end

    task automatic exp_bus(input bit src, input logic wr, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus_exp_t e;
        e.src = src; e.wr = wr; e.strb = strb; e.addr = addr; e.wdata = wdata;
        exp_bus_q.push_back(e);
    endtask

    task automatic drive_inst(input logic [31:0] addr);
        int t = 0;
        inst_req  = 1'b1;
        inst_addr = addr;
        exp_inst_q.push_back(rsp_fn(addr));
        do begin @(negedge clk); t++; end while (!inst_addr_ok && t < 200);
        if (!inst_addr_ok) chk("inst_addr_ok_timeout", 0, 1);
        @(posedge clk); #1;
        inst_req = 1'b0;
    endtask

    task automatic drive_data(input logic wr, input logic [3:0] strb,
                              input logic [31:0] addr, input logic [31:0] wdata);
        int t = 0;
        rsp_exp_t r;
        data_req = 1'b1; data_wr = wr; data_wstrb = strb;
        data_addr = addr; data_wdata = wdata;
        r.wr = wr; r.rdata = rsp_fn(addr);
        exp_data_q.push_back(r);
        do begin @(negedge clk); t++; end while (!data_addr_ok && t < 200);
        if (!data_addr_ok) chk("data_addr_ok_timeout", 0, 1);
        @(posedge clk); #1;
        data_req = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((m_st != S_IDLE || inst_req || data_req || exp_bus_q.size() != 0
                || exp_inst_q.size() != 0 || exp_data_q.size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0;
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_wr", bus_wr, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_stallreq", stallreq, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        chk("rst_inst_rdata", inst_rdata, 0);
        chk("rst_data_rdata", data_rdata, 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 resetn = 1'b0;
        do_reset();

        // Inst-only read, zero-wait slave: cycle-exact latency.
        @(posedge clk); #1;
        exp_bus(0, 0, 4'h0, 32'hBFC0_0000, 32'h0);
        exp_inst_q.push_back(32'h3C1D_0000);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        @(negedge clk);
        chk("t1_c0_bus_req", bus_req, 0);
        chk("t1_c0_stallreq", stallreq, 1);
        @(negedge clk);
        chk("t1_c1_bus_req", bus_req, 1);
        chk("t1_c1_inst_addr_ok", inst_addr_ok, 1);
        @(posedge clk); #1;
        inst_req = 1'b0;
        @(negedge clk);
        chk("t1_c2_inst_data_ok", inst_data_ok, 1);
        chk("t1_c2_inst_rdata", inst_rdata, 32'h3C1D_0000);
        chk("t1_c2_bus_req", bus_req, 0);
        @(negedge clk);
        chk("t1_c3_stallreq", stallreq, 0);
        wait_idle();

        // Simultaneous fetch and data write: data goes first.
        do_reset();
        exp_bus(1, 1, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF);
        exp_bus(0, 0, 4'h0, 32'hBFC0_0010, 32'h0);
        @(posedge clk); #1;
        fork
            drive_data(1'b1, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF);
            drive_inst(32'hBFC0_0010);
        join
        wait_idle();

        // Slow slave: 3-cycle addr_ok, 5-cycle data_ok.
        addr_dly = 3; data_dly = 5;
        exp_bus(1, 1, 4'h3, 32'h8000_0100, 32'hCAFE_F00D);
        exp_bus(0, 0, 4'h0, 32'hBFC0_0020, 32'h0);
        @(posedge clk); #1;
        fork
            drive_data(1'b1, 4'h3, 32'h8000_0100, 32'hCAFE_F00D);
            drive_inst(32'hBFC0_0020);
        join
        wait_idle();
        addr_dly = 0; data_dly = 0;

        // Starvation guard: D,D,D,D,I,D,D,D,D,I.
        do_reset();
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 4; k++) begin
                exp_bus(1, 1'((g * 4 + k) % 2), 4'hF, 32'h8000_0000 + 32'((g * 4 + k) * 4),
                        32'h1000_0000 + 32'(g * 4 + k));
            end
            exp_bus(0, 0, 4'h0, 32'hBFC0_0100 + 32'(g * 4), 32'h0);
        end
        @(posedge clk); #1;
        fork
            for (int k = 0; k < 8; k++) begin
                drive_data(1'(k % 2), 4'hF, 32'h8000_0000 + 32'(k * 4), 32'h1000_0000 + 32'(k));
            end
            for (int j = 0; j < 2; j++) begin
                drive_inst(32'hBFC0_0100 + 32'(j * 4));
            end
        join
        wait_idle();

        // Reset during DATA, then a late bus_data_ok in IDLE.
        data_dly = 20;
        exp_bus(1, 0, 4'h0, 32'h8000_0300, 32'h0);
        @(posedge clk); #1;
        drive_data(1'b0, 4'h0, 32'h8000_0300, 32'h0);
        begin
            int t = 0;
            while (m_st != S_DATA && t < 50) begin @(negedge clk); t++; end
            chk("t5_reached_data", (m_st == S_DATA), 1);
        end
        @(negedge clk);
        slave_en = 1'b0;
        do_reset();
        data_dly = 0;
        @(posedge clk); #1;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h5555_AAAA;
        @(negedge clk);
        chk("t5_spur_data_data_ok", data_data_ok, 0);
        chk("t5_spur_inst_data_ok", inst_data_ok, 0);
        chk("t5_spur_stallreq", stallreq, 0);
        chk("t5_spur_bus_req", bus_req, 0);
        chk("t5_spur_data_rdata", data_rdata, 0);
        @(posedge clk); #1;
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk("t5_after_bus_req", bus_req, 0);
        chk("t5_after_bus_addr", bus_addr, 0);
        slave_en = 1'b1;

        // Data read returning a fixed word; fetch side must stay quiet.
        exp_bus(1, 0, 4'h0, 32'h8000_2004, 32'h0);
        @(posedge clk); #1;
        drive_data(1'b0, 4'h0, 32'h8000_2004, 32'h0);
        @(negedge clk);
        chk("t6_data_data_ok", data_data_ok, 1);
        chk("t6_data_rdata", data_rdata, 32'h1234_5678);
        chk("t6_inst_data_ok", inst_data_ok, 0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
